fused_frame_serializer: RTL and testbench
=========================================

Name: fused_frame_serializer

Overview:
- Output-side counterpart of the temporal alignment top-level: consumes one wide fused frame (3840 bits plus timestamp and error flag, single-cycle valid pulse) and streams it as 64-bit beats on a valid/ready stream to the downstream fusion core or DMA.
- Holds one pending frame while another is being streamed. Frames arriving with no free slot are dropped and counted.

Parameters:
- FRAME_WIDTH, 3840, fused frame width in bits; must be a multiple of BEAT_WIDTH.
- BEAT_WIDTH, 64, output beat width.
- TS_WIDTH, 64, timestamp width; must equal BEAT_WIDTH.
- NUM_BEATS, FRAME_WIDTH/BEAT_WIDTH (60), derived payload beat count.
- DROP_CNT_W, 16, drop counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_data  in  FRAME_WIDTH  fused frame
- frame_ts  in  TS_WIDTH  t_common of the frame
- frame_err  in  1  alignment error flag for the frame
- frame_valid  in  1  single-cycle frame strobe; upstream cannot stall
- frame_ready  out  1  pending slot can accept this cycle
- m_data  out  BEAT_WIDTH  beat data
- m_valid  out  1  beat valid
- m_ready  in  1  downstream accept
- m_sof  out  1  first beat of frame (header)
- m_eof  out  1  last beat of frame
- m_err  out  1  copy of frame_err, held on every beat of the frame
- busy  out  1  FSM not in IDLE or pending slot occupied
- drop_count  out  DROP_CNT_W  saturating count of dropped frames

Behaviour:
- Reset, asynchronous: FSM=IDLE, pending_valid=0, beat_idx=0. m_valid, m_sof, m_eof, m_err, busy = 0. m_data=0, drop_count=0. Takes effect immediately mid-frame; the partial frame is discarded with no eof.
- Accept:
  - accept = frame_valid & frame_ready.
  - frame_ready = !pending_valid | pend_pop. pend_pop is the cycle the pending slot moves to the active register, so the slot frees and refills in the same cycle.
  - On accept, {data, ts, err} is registered into the pending slot.
- Drop: frame_valid & !frame_ready increments drop_count. It saturates at all-ones and never wraps. The frame is discarded.
- FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE: if pending_valid, pend_pop, load active, go to HEADER.
  - HEADER: m_valid=1, m_data=ts, m_sof=1. On handshake go to PAYLOAD with beat_idx=0.
  - PAYLOAD: m_data = active[BEAT_WIDTH*beat_idx +: BEAT_WIDTH], LSB slice first. On handshake beat_idx increments.
    - At beat_idx=NUM_BEATS-1, m_eof=1.
    - On that handshake: if pending_valid, pend_pop and go to HEADER (no bubble); else go to IDLE.
- Frame length: 1 header + NUM_BEATS payload beats = 61 beats.
- Latency:
  - frame_valid in cycle 0 with FSM idle: header m_valid in cycle 2 (pending in cycle 1, pop at end of cycle 1).
  - Back-to-back: header of the next frame follows the eof handshake with zero idle cycles.
- Stream rules:
  - While m_valid & !m_ready, m_data, m_sof, m_eof, m_err are held stable.
  - m_valid never drops without a handshake, except on reset.
- m_err is constant for all 61 beats of a frame.
- Storage: at most one frame streaming plus one pending.
  - A third frame arriving while both are occupied and no pop occurs is dropped.
  - A frame arriving in the pend_pop cycle is accepted.
- beat_idx width: clog2(NUM_BEATS). Beat indexing never exceeds NUM_BEATS-1.
- All outputs are registered except frame_ready, which is combinational on pending_valid, state and m_ready.

Decomposition:
- Shared package fusion_pkg holds:
  - FUSED_FRAME_WIDTH=3840, FUSION_BEAT_WIDTH=64, TS_WIDTH=64, NUM_BEATS.
  - Sensor slice offsets: lidar 0..511, camera 512..3583, radar 3584..3711, imu 3712..3775.
  - typedef enum ser_state_t {IDLE, HEADER, PAYLOAD}.
- Single module. No sub-module warranted; the pending slot and FSM are too tightly coupled through pend_pop to split.

Test Plan:
- Single frame, m_ready=1:
  - Stimulus: frame_data beat k = 64'h0000_0000_0000_00kk, ts=64'h1234, err=0, valid pulse at cycle 0.
  - Required: header 0x1234 with sof in cycle 2; beats 0..59 in cycles 3..62; eof in cycle 62; busy low in cycle 63.
- Backpressure:
  - Stimulus: m_ready toggled 1,0,0,1 repeating.
  - Required: m_data/sof/eof stable across stalls; exactly 61 handshakes; payload order matches beat index.
- Back-to-back:
  - Stimulus: frame A ts=1 at cycle 0, frame B ts=2 at cycle 5.
  - Required: B's header beat (ts=2) appears in the cycle immediately after A's eof handshake; drop_count=0.
- Overflow:
  - Stimulus: frames at cycles 0, 5, 10 with m_ready=0.
  - Required: first two held (one active, one pending); third dropped; drop_count=1; frame_ready low at cycle 10.
- Pop-cycle capture and saturation:
  - Stimulus: new frame_valid exactly in the pend_pop cycle.
  - Required: frame accepted, no drop. Separately, drop_count preloaded by repeated overflows saturates at 16'hFFFF.
- Reset mid-frame:
  - Stimulus: rst_n low at payload beat 30 with err=1 frame.
  - Required: m_valid=0, m_err=0, drop_count=0 immediately. A new frame after release starts with sof and a clean header.

Source files
------------

// File: rtl/fusion_pkg.sv
// fusion_pkg: constants and types shared by the sensor-fusion output path.
//   FUSED_FRAME_WIDTH  width of one fused frame in bits
//   FUSION_BEAT_WIDTH  width of one output stream beat
//   TS_WIDTH           width of the common timestamp (one header beat)
//   NUM_BEATS          payload beats per frame
//   *_LO / *_HI        bit ranges of each sensor slice inside a fused frame
//   ser_state_t        serializer FSM state
package fusion_pkg;

  localparam int FUSED_FRAME_WIDTH = 3840;
  localparam int FUSION_BEAT_WIDTH = 64;
  localparam int TS_WIDTH          = 64;
  localparam int NUM_BEATS         = FUSED_FRAME_WIDTH / FUSION_BEAT_WIDTH;

  localparam int LIDAR_LO  = 0;
  localparam int LIDAR_HI  = 511;
  localparam int CAMERA_LO = 512;
  localparam int CAMERA_HI = 3583;
  localparam int RADAR_LO  = 3584;
  localparam int RADAR_HI  = 3711;
  localparam int IMU_LO    = 3712;
  localparam int IMU_HI    = 3775;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } ser_state_t;

endpackage

// File: rtl/fused_frame_serializer.sv
// fused_frame_serializer: takes one wide fused frame per single-cycle strobe
// and streams it as 1 header beat (timestamp) + NUM_BEATS payload beats,
// LSB slice first. One frame may wait in a pending slot while another streams;
// frames arriving with no free slot are dropped and counted (saturating).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_data/ts/err fused frame, its timestamp and alignment error flag
//   frame_valid       single-cycle strobe, upstream cannot stall
//   frame_ready       pending slot can take a frame this cycle (combinational)
//   m_data/m_valid    output beat stream
//   m_ready           downstream accept
//   m_sof/m_eof       header beat / last payload beat markers
//   m_err             frame error flag, constant across the frame
//   busy              streaming or holding a pending frame
//   drop_count        saturating count of dropped frames
//
// Stream handshake: a beat transfers on a cycle where m_valid && m_ready.
// Once m_valid is raised, m_valid/m_data/m_sof/m_eof/m_err hold until that
// transfer; only reset can withdraw a beat.
module fused_frame_serializer #(
  parameter int FRAME_WIDTH = fusion_pkg::FUSED_FRAME_WIDTH,
  parameter int BEAT_WIDTH  = fusion_pkg::FUSION_BEAT_WIDTH,
  parameter int TS_WIDTH    = fusion_pkg::TS_WIDTH,
  parameter int NUM_BEATS   = FRAME_WIDTH / BEAT_WIDTH,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  input  logic [TS_WIDTH-1:0]    frame_ts,
  input  logic                   frame_err,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [BEAT_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic                   m_err,
  output logic                   busy,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  import fusion_pkg::*;

  localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  ser_state_t             state;
  logic                   pending_valid;
  logic [FRAME_WIDTH-1:0] pend_data;
  logic [TS_WIDTH-1:0]    pend_ts;
  logic                   pend_err;
  logic [FRAME_WIDTH-1:0] active_data;
  logic [IDX_W-1:0]       beat_idx;
  logic [IDX_W-1:0]       next_idx;
  logic                   hs;
  logic                   last_hs;
  logic                   pend_pop;
  logic                   accept;
  logic                   busy_nxt;

  assign hs       = m_valid & m_ready;
  assign last_hs  = hs & (state == PAYLOAD) & (beat_idx == LAST_IDX);
  // The slot empties either from IDLE or on the eof transfer, so the next
  // header follows the eof with no bubble.
  assign pend_pop = pending_valid & ((state == IDLE) | last_hs);
  // A frame arriving while the slot is being popped refills it at once.
  assign frame_ready = ~pending_valid | pend_pop;
  assign accept      = frame_valid & frame_ready;
  assign next_idx    = beat_idx + IDX_W'(1);

  // Busy next cycle: a frame is (or will be) pending, or the FSM stays active.
  assign busy_nxt = accept | pending_valid | (state == HEADER) |
                    ((state == PAYLOAD) & ~last_hs);

  // Frame storage carries no reset; the valid flags below qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_data <= frame_data;
      pend_ts   <= frame_ts;
      pend_err  <= frame_err;
    end
    if (pend_pop) begin
      active_data <= pend_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending_valid <= 1'b0;
      beat_idx      <= '0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      m_sof         <= 1'b0;
      m_eof         <= 1'b0;
      m_err         <= 1'b0;
      busy          <= 1'b0;
      drop_count    <= '0;
    end else begin
      busy <= busy_nxt;

      if (accept) begin
        pending_valid <= 1'b1;
      end else if (pend_pop) begin
        pending_valid <= 1'b0;
      end

      if (frame_valid && !frame_ready && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end

      if (pend_pop) begin
        // Header beat of the frame leaving the pending slot.
        state    <= HEADER;
        beat_idx <= '0;
        m_valid  <= 1'b1;
        m_data   <= pend_ts;
        m_sof    <= 1'b1;
        m_eof    <= 1'b0;
        m_err    <= pend_err;
      end else begin
        case (state)
          IDLE: begin
            m_valid <= 1'b0;
          end
          HEADER: begin
            if (hs) begin
              state    <= PAYLOAD;
              beat_idx <= '0;
              m_data   <= active_data[0 +: BEAT_WIDTH];
              m_sof    <= 1'b0;
              m_eof    <= (NUM_BEATS == 1);
            end
          end
          PAYLOAD: begin
            if (last_hs) begin
              state    <= IDLE;
              beat_idx <= '0;
              m_valid  <= 1'b0;
              m_data   <= '0;
              m_eof    <= 1'b0;
              m_err    <= 1'b0;
            end else if (hs) begin
              beat_idx <= next_idx;
              m_data   <= active_data[BEAT_WIDTH*next_idx +: BEAT_WIDTH];
              m_eof    <= (next_idx == LAST_IDX);
            end
          end
          default: begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fused_frame_serializer.sv
// tb_fused_frame_serializer: randomized and directed stimulus against a
// frame-level reference model (pending-frame count, streaming flag, expected
// beat queue, drop count).
module tb_fused_frame_serializer;

  localparam int FW    = 3840;
  localparam int BW    = 64;
  localparam int NB    = FW / BW;
  localparam int FLEN  = NB + 1;
  localparam int W     = BW + 3;   // {err, eof, sof, data}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] frame_data = '0;
  logic [63:0]   frame_ts = '0;
  logic          frame_err = 1'b0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sof;
  logic          m_eof;
  logic          m_err;
  logic          busy;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  fused_frame_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_data (frame_data),
    .frame_ts   (frame_ts),
    .frame_err  (frame_err),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .m_err      (m_err),
    .busy       (busy),
    .drop_count (drop_count)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           wait_cnt = 0;   // accepted frames not yet started
  bit           m_active = 0;   // a frame is on the stream
  int           m_rem = 0;      // beats of that frame still to transfer
  int           m_drop = 0;
  int           cyc = 0;
  int           hs_cnt = 0;
  int           sof_cycs[$];
  int           eof_cycs[$];
  logic         last_ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [FW-1:0] count_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NB; k++) f[BW*k +: BW] = 64'(k);
    return f;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic fv, input logic [FW-1:0] fd, input logic [63:0] ts,
                      input logic fe, input logic mr);
    bit hs, pop, rdy, stall;
    logic [W:0] prev_out;
    logic [W-1:0] e;
    frame_valid = fv;
    frame_data  = fd;
    frame_ts    = ts;
    frame_err   = fe;
    m_ready     = mr;
    #1;
    hs  = m_active && mr;
    pop = (wait_cnt > 0) && (!m_active || (hs && m_rem == 1));
    rdy = (wait_cnt == 0) || pop;
    last_ready = frame_ready;
    check("frame_ready", frame_ready, rdy);
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("beat", {m_err, m_eof, m_sof, m_data}, e);
        if (e[BW]) sof_cycs.push_back(cyc);
        if (e[BW+1]) eof_cycs.push_back(cyc);
      end
      m_rem--;
      if (m_rem == 0) m_active = 0;
    end
    if (pop) begin
      wait_cnt--;
      m_active = 1;
      m_rem = FLEN;
    end
    if (fv) begin
      if (rdy) begin
        wait_cnt++;
        exp_q.push_back({fe, 1'b0, 1'b1, ts});
        for (int k = 0; k < NB; k++) exp_q.push_back({fe, k == NB - 1, 1'b0, fd[BW*k +: BW]});
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    stall = m_valid && !mr;
    prev_out = {m_valid, m_err, m_eof, m_sof, m_data};
    @(negedge clk);
    cyc++;
    check("m_valid", m_valid, m_active);
    check("busy", busy, m_active || (wait_cnt > 0));
    check("drop_count", drop_count, m_drop);
    if (stall) check("stall_hold", {m_valid, m_err, m_eof, m_sof, m_data}, prev_out);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, '0, 64'd0, 1'b0, mr);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_active || wait_cnt > 0); i++) step(1'b0, '0, 64'd0, 1'b0, 1'b1);
    check("drain_empty", 128'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_valid = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_err", m_err, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    check("rst_sof_eof", {m_sof, m_eof}, 0);
    check("rst_m_data", m_data, 0);
    exp_q.delete();
    wait_cnt = 0;
    m_active = 0;
    m_rem = 0;
    m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int d0;
    logic [FW-1:0] f;
    logic [3:0] pat;
    pat = 4'b1001;   // m_ready 1,0,0,1 read LSB first

    @(negedge clk);
    do_reset();

    // Single frame, m_ready held high
    sof_cycs.delete(); eof_cycs.delete();
    c0 = cyc;
    step(1'b1, count_frame(), 64'h1234, 1'b0, 1'b1);
    idle(70, 1'b1);
    check("single_hdr_cycle", 128'(sof_cycs[0]), 128'(c0 + 2));
    check("single_eof_cycle", 128'(eof_cycs[0]), 128'(c0 + 62));
    check("single_empty", 128'(exp_q.size()), 0);

    // Backpressure 1,0,0,1
    hs_cnt = 0;
    step(1'b1, rand_frame(), 64'hABCD, 1'b1, 1'b1);
    for (int i = 0; i < 400 && (m_active || wait_cnt > 0); i++)
      step(1'b0, '0, 64'd0, 1'b0, pat[i % 4]);
    check("bp_handshakes", 128'(hs_cnt), FLEN);
    drain();

    // Back-to-back frames
    sof_cycs.delete(); eof_cycs.delete();
    for (int i = 0; i < 140; i++) begin
      if (i == 0) step(1'b1, rand_frame(), 64'd1, 1'b0, 1'b1);
      else if (i == 5) step(1'b1, rand_frame(), 64'd2, 1'b0, 1'b1);
      else step(1'b0, '0, 64'd0, 1'b0, 1'b1);
    end
    check("b2b_count", 128'(sof_cycs.size()), 2);
    if (sof_cycs.size() == 2 && eof_cycs.size() >= 1)
      check("b2b_gap", 128'(sof_cycs[1]), 128'(eof_cycs[0] + 1));
    check("b2b_drop", drop_count, 0);

    // Overflow with m_ready low
    d0 = m_drop;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 5 || i == 10) step(1'b1, rand_frame(), 64'(100 + i), 1'b0, 1'b0);
      else step(1'b0, '0, 64'd0, 1'b0, 1'b0);
      if (i == 10) check("ovf_ready10", last_ready, 0);
    end
    check("ovf_drop", drop_count, 128'(d0 + 1));
    drain();

    // Capture in the pop cycle: IDLE pop, then eof pop
    d0 = m_drop;
    step(1'b1, rand_frame(), 64'h11, 1'b0, 1'b1);
    step(1'b1, rand_frame(), 64'h22, 1'b1, 1'b1);
    check("idle_pop_ready", last_ready, 1);
    drain();
    hs_cnt = 0;
    eof_cycs.delete();
    for (int i = 0; i < 63; i++) begin
      if (i == 0 || i == 5 || i == 62) step(1'b1, rand_frame(), 64'(200 + i), 1'b0, 1'b1);
      else step(1'b0, '0, 64'd0, 1'b0, 1'b1);
      if (i == 62) check("pop_cycle_ready", last_ready, 1);
    end
    check("pop_eof_cycle", 128'(eof_cycs[0]), 128'(cyc - 1));
    drain();
    check("pop_handshakes", 128'(hs_cnt), 3 * FLEN);
    check("pop_drop", drop_count, 128'(d0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) step(1'b1, rand_frame(), {$urandom, $urandom}, 1'($urandom), 1'($urandom_range(0, 3) != 0));
      else step(1'b0, '0, 64'd0, 1'b0, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Drop counter saturation
    f = rand_frame();
    for (int i = 0; i < 65545; i++) step(1'b1, f, 64'd7, 1'b0, 1'b0);
    check("sat_drop", drop_count, 16'hFFFF);
    drain();

    // Reset during payload beat 30 of an err=1 frame
    step(1'b1, rand_frame(), 64'h5A5A, 1'b1, 1'b1);
    idle(33, 1'b1);
    check("pre_rst_err", m_err, 1);
    do_reset();
    sof_cycs.delete();
    c0 = cyc;
    step(1'b1, rand_frame(), 64'h77, 1'b0, 1'b1);
    idle(70, 1'b1);
    check("post_rst_hdr", 128'(sof_cycs[0]), 128'(c0 + 2));
    check("post_rst_empty", 128'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
